// File: rtl/pulse_channel.sv
// pulse_channel: rectangle-wave voice with period timer, 8-step duty
// sequencer, length counter and optional frequency sweep.
// Optional feature macro: PULSE_SWEEP_EN (enables the period sweep unit).
module pulse_channel #(
  parameter int TIMER_W = 11,
  parameter int VOL_W   = 4,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               iReset_n,
  input  logic               iEnable,
  input  logic [1:0]         iDuty_cycle_type,
  input  logic [TIMER_W-1:0] iPeriod,
  input  logic [VOL_W-1:0]   iVolume,
  input  logic [LEN_W-1:0]   iLength,
  input  logic               iLoad,
  input  logic               iHalt,
  input  logic               iFrame_tick,
  input  logic               iSweep_en,
  input  logic               iSweep_negate,
  input  logic [2:0]         iSweep_shift,
  input  logic               iSweep_tick,
  output logic [VOL_W-1:0]   oData,
  output logic               oActive
);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] period_q, period_d;
  logic [2:0]         position_q, position_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [VOL_W-1:0]   data_q, data_d;
  logic               active_q, active_d;

  logic [7:0]         pattern;
  logic [TIMER_W:0]   target;
  logic               sweep_mute;
  logic               sweep_apply;
  logic               mute;
  logic               load_go;

`ifdef PULSE_SWEEP_EN
  // Sweep target is computed one bit wider so an overflowing add is visible.
  always_comb begin
    logic [TIMER_W:0] delta;
    delta       = {1'b0, period_q} >> iSweep_shift;
    target      = iSweep_negate ? ({1'b0, period_q} - delta)
                                : ({1'b0, period_q} + delta);
    sweep_mute  = ~iSweep_negate & target[TIMER_W];
    sweep_apply = iSweep_tick & iSweep_en & (iSweep_shift != 3'd0) & ~sweep_mute;
  end
`else
  logic unused_sweep;
  assign unused_sweep = ^{iSweep_en, iSweep_negate, iSweep_shift, iSweep_tick};

  // Without the sweep unit the period only changes on a load.
  always_comb begin
    target      = {1'b0, period_q};
    sweep_mute  = 1'b0;
    sweep_apply = 1'b0;
  end
`endif

  // Duty waveform lookup, bit index is the sequencer position.
  always_comb begin
    pattern = 8'b0000_0001;
    case (iDuty_cycle_type)
      2'd0:    pattern = 8'b0000_0001;
      2'd1:    pattern = 8'b0000_0011;
      2'd2:    pattern = 8'b0000_1111;
      default: pattern = 8'b1111_1100;
    endcase
  end

  // Next-state logic: a load wins over the timer, frame tick and sweep.
  always_comb begin
    load_go    = iEnable & iLoad;
    timer_d    = timer_q;
    period_d   = period_q;
    position_d = position_q;
    length_d   = length_q;

    if (load_go) begin
      timer_d    = iPeriod;
      period_d   = iPeriod;
      position_d = 3'd0;
      length_d   = iLength;
    end else begin
      if (timer_q == '0) begin
        timer_d    = period_q;
        position_d = position_q - 3'd1;
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end

      if (!iEnable) begin
        length_d = '0;
      end else if (iFrame_tick && !iHalt && (length_q != '0)) begin
        length_d = length_q - LEN_W'(1);
      end

      if (sweep_apply) begin
        period_d = target[TIMER_W-1:0];
      end
    end

    mute     = (length_q == '0) || (period_q < TIMER_W'(8)) || sweep_mute;
    data_d   = (!mute && pattern[position_q]) ? iVolume : '0;
    active_d = (length_q != '0);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      timer_q    <= '0;
      period_q   <= '0;
      position_q <= '0;
      length_q   <= '0;
      data_q     <= '0;
      active_q   <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      period_q   <= period_d;
      position_q <= position_d;
      length_q   <= length_d;
      data_q     <= data_d;
      active_q   <= active_d;
    end
  end

  assign oData   = data_q;
  assign oActive = active_q;

endmodule

// File: tb/tb_pulse_channel.sv
// Testbench for pulse_channel: directed checks plus randomized traffic
// compared every cycle against a cycle-count based reference model.
module tb_pulse_channel;

  logic        clk = 1'b0;
  logic        iReset_n = 1'b1;
  logic        iEnable = 1'b0;
  logic [1:0]  iDuty_cycle_type = 2'd0;
  logic [10:0] iPeriod = '0;
  logic [3:0]  iVolume = '0;
  logic [7:0]  iLength = '0;
  logic        iLoad = 1'b0;
  logic        iHalt = 1'b0;
  logic        iFrame_tick = 1'b0;
  logic        iSweep_en = 1'b0;
  logic        iSweep_negate = 1'b0;
  logic [2:0]  iSweep_shift = '0;
  logic        iSweep_tick = 1'b0;
  logic [3:0]  oData;
  logic        oActive;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference model state: notes are described by edge counts, not a timer.
  logic [7:0] patterns [4] = '{8'h01, 8'h03, 8'h0F, 8'hFC};
  int mEdge = 0;
  int mNextStep = 1;
  int mSteps = 0;
  int mPeriod = 0;
  int mLength = 0;
  int mPos;
  int mTarget;
  bit mSweepMute;
  int expData = 0;
  int expActive = 0;

  pulse_channel dut (
    .clk              (clk),
    .iReset_n         (iReset_n),
    .iEnable          (iEnable),
    .iDuty_cycle_type (iDuty_cycle_type),
    .iPeriod          (iPeriod),
    .iVolume          (iVolume),
    .iLength          (iLength),
    .iLoad            (iLoad),
    .iHalt            (iHalt),
    .iFrame_tick      (iFrame_tick),
    .iSweep_en        (iSweep_en),
    .iSweep_negate    (iSweep_negate),
    .iSweep_shift     (iSweep_shift),
    .iSweep_tick      (iSweep_tick),
    .oData            (oData),
    .oActive          (oActive)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Load a note: one-cycle load pulse, returns just after the load edge.
  task automatic applyStimulus(input logic [10:0] period, input logic [7:0] len);
    iPeriod = period;
    iLength = len;
    iLoad   = 1'b1;
    @(negedge clk);
    iLoad   = 1'b0;
  endtask

  // Model reset mirrors the asynchronous clear; timer empty so the next edge steps.
  always @(negedge iReset_n) begin
    mLength   = 0;
    mPeriod   = 0;
    mSteps    = 0;
    mNextStep = mEdge + 1;
    expData   = 0;
    expActive = 0;
  end

  // Reference model: position = steps taken since load, counted backwards mod 8.
  always @(posedge clk) begin
    mEdge = mEdge + 1;
    if (!iReset_n) begin
      mNextStep = mEdge + 1;
    end else begin
      mPos       = (8 - (mSteps % 8)) % 8;
      mTarget    = mPeriod;
      mSweepMute = 1'b0;
`ifdef PULSE_SWEEP_EN
      mTarget    = iSweep_negate ? mPeriod - (mPeriod >> iSweep_shift)
                                 : mPeriod + (mPeriod >> iSweep_shift);
      mSweepMute = !iSweep_negate && (mTarget > 2047);
`endif
      if (mLength == 0 || mPeriod < 8 || mSweepMute)
        expData = 0;
      else
        expData = patterns[iDuty_cycle_type][mPos] ? int'(iVolume) : 0;
      expActive = (mLength != 0) ? 1 : 0;

      if (iEnable && iLoad) begin
        mLength   = int'(iLength);
        mPeriod   = int'(iPeriod);
        mSteps    = 0;
        mNextStep = mEdge + int'(iPeriod) + 1;
      end else begin
        if (mEdge == mNextStep) begin
          mSteps    = mSteps + 1;
          mNextStep = mEdge + mPeriod + 1;
        end
        if (!iEnable)
          mLength = 0;
        else if (iFrame_tick && !iHalt && mLength > 0)
          mLength = mLength - 1;
`ifdef PULSE_SWEEP_EN
        if (iSweep_tick && iSweep_en && iSweep_shift != 3'd0 && !mSweepMute)
          mPeriod = mTarget;
`endif
      end
    end
  end

  // Cycle-by-cycle comparison of both outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_data", 32'(oData), 32'(expData));
      checkOutput("model_active", 32'(oActive), 32'(expActive));
    end
  end

  initial begin
    #1 iReset_n = 1'b0;
    #1;
    checkOutput("reset_data", 32'(oData), 32'h0);
    checkOutput("reset_active", 32'(oActive), 32'h0);
    repeat (3) @(negedge clk);
    iReset_n = 1'b1;
    checkEn  = 1'b1;
    iEnable  = 1'b1;

    // Duty type 2, period 9: sequencer steps every 10 cycles.
    iDuty_cycle_type = 2'd2;
    iVolume = 4'hA;
    applyStimulus(11'd9, 8'd200);
    @(negedge clk);
    checkOutput("t1_first", 32'(oData), 32'hA);
    checkOutput("t1_active", 32'(oActive), 32'h1);
    repeat (9) @(negedge clk);
    checkOutput("t1_pos0_end", 32'(oData), 32'hA);
    @(negedge clk);
    checkOutput("t1_pos7", 32'(oData), 32'h0);
    repeat (30) @(negedge clk);
    checkOutput("t1_pos4", 32'(oData), 32'h0);
    repeat (10) @(negedge clk);
    checkOutput("t1_pos3", 32'(oData), 32'hA);

    // Period below 8 is silent but the note is still active.
    applyStimulus(11'd5, 8'd200);
    repeat (3) @(negedge clk);
    checkOutput("short_period_data", 32'(oData), 32'h0);
    checkOutput("short_period_active", 32'(oActive), 32'h1);

    // Length 3 expires on the third frame tick.
    applyStimulus(11'd9, 8'd3);
    for (int i = 0; i < 3; i++) begin
      iFrame_tick = 1'b1;
      @(negedge clk);
      iFrame_tick = 1'b0;
      if (i < 2) @(negedge clk);
    end
    checkOutput("len_last_tick", 32'(oActive), 32'h1);
    @(negedge clk);
    checkOutput("len_expired_active", 32'(oActive), 32'h0);
    checkOutput("len_expired_data", 32'(oData), 32'h0);

    // Same with halt held: counter frozen.
    applyStimulus(11'd9, 8'd3);
    iHalt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iFrame_tick = 1'b1;
      @(negedge clk);
      iFrame_tick = 1'b0;
      @(negedge clk);
    end
    checkOutput("halt_active", 32'(oActive), 32'h1);
    iHalt = 1'b0;

    // Disable mid-note, then a load while disabled is ignored.
    applyStimulus(11'd9, 8'd50);
    repeat (2) @(negedge clk);
    iEnable = 1'b0;
    @(negedge clk);
    checkOutput("disable_one", 32'(oActive), 32'h1);
    @(negedge clk);
    checkOutput("disable_two", 32'(oActive), 32'h0);
    applyStimulus(11'd9, 8'd50);
    @(negedge clk);
    checkOutput("disabled_load", 32'(oActive), 32'h0);
    iEnable = 1'b1;

    // Asynchronous reset in the middle of a sounding note.
    applyStimulus(11'd9, 8'd200);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_data", 32'(oData), 32'hA);
    @(posedge clk);
    #2 iReset_n = 1'b0;
    #1;
    checkOutput("async_reset_data", 32'(oData), 32'h0);
    checkOutput("async_reset_active", 32'(oActive), 32'h0);
    @(negedge clk);
    iReset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_silent", 32'(oActive), 32'h0);

`ifdef PULSE_SWEEP_EN
    // Sweep add, subtract and overflow mute.
    iSweep_en = 1'b1;
    iSweep_shift = 3'd1;
    iSweep_negate = 1'b0;
    applyStimulus(11'h400, 8'd200);
    iSweep_tick = 1'b1;
    @(negedge clk);
    iSweep_tick = 1'b0;
    checkOutput("sweep_add", 32'(mPeriod), 32'h600);
    iSweep_negate = 1'b1;
    applyStimulus(11'h400, 8'd200);
    iSweep_tick = 1'b1;
    @(negedge clk);
    iSweep_tick = 1'b0;
    checkOutput("sweep_sub", 32'(mPeriod), 32'h200);
    iSweep_negate = 1'b0;
    applyStimulus(11'h7F0, 8'd200);
    iSweep_tick = 1'b1;
    @(negedge clk);
    iSweep_tick = 1'b0;
    checkOutput("sweep_ovf_period", 32'(mPeriod), 32'h7F0);
    @(negedge clk);
    checkOutput("sweep_ovf_mute", 32'(oData), 32'h0);
    checkOutput("sweep_ovf_active", 32'(oActive), 32'h1);
    iSweep_en = 1'b0;
    iSweep_shift = 3'd0;
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      iEnable       = ($urandom_range(0, 31) != 0);
      iLoad         = ($urandom_range(0, 11) == 0);
      iPeriod       = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                  : 11'($urandom_range(0, 24));
      iLength       = 8'($urandom_range(0, 12));
      iFrame_tick   = ($urandom_range(0, 5) == 0);
      iHalt         = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) iDuty_cycle_type = 2'($urandom_range(0, 3));
      iVolume       = 4'($urandom_range(0, 15));
      iSweep_en     = 1'($urandom_range(0, 1));
      iSweep_negate = 1'($urandom_range(0, 1));
      iSweep_shift  = 3'($urandom_range(0, 7));
      iSweep_tick   = ($urandom_range(0, 7) == 0);
      if (i == 2000) begin
        #2 iReset_n = 1'b0;
        #4 iReset_n = 1'b1;
      end
      @(negedge clk);
    end

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
